didactic_obi_apb_bridge: RTL and testbench

Single-outstanding OBI-to-APB bridge that gives the system controller's OBI master access to the NUM_SS subsystem APB slaves, including the student domain. It decodes the OBI address into one subsystem window, and blocks access to subsystems whose enable bit is clear. It then sequences a standard two-phase APB transfer and returns the result as an OBI response. It sits between the system-control OBI port and the per-subsystem APB ports in the interconnect.

---
 rtl/didactic_obi_apb_pkg.sv | 22 ++
 rtl/didactic_apb_addr_decode.sv | 29 ++
 rtl/didactic_obi_apb_bridge.sv | 182 ++++++++++++++++++
 tb/tb_didactic_obi_apb_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/didactic_obi_apb_pkg.sv
// rtl/didactic_obi_apb_pkg.sv - shared types and defaults for the OBI-to-APB bridge
package didactic_obi_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } bridge_state_e;

  localparam logic [31:0] SS_BASE_DEFAULT = 32'h0100_0000;

  // The response ID field is sized by this default; the bridge casts to and from OBI_IDW.
  localparam int unsigned ObiIdw = 1;

  typedef struct packed {
    logic [31:0]       rdata;
    logic [ObiIdw-1:0] rid;
    logic              err;
  } obi_rsp_t;

endpackage

// File: rtl/didactic_apb_addr_decode.sv
// rtl/didactic_apb_addr_decode.sv - combinational OBI address to subsystem window decoder
module didactic_apb_addr_decode
  import didactic_obi_apb_pkg::*;
#(
  parameter int unsigned NUM_SS       = 5,
  parameter int unsigned ApbAddrWidth = 12,
  parameter int unsigned IdxW         = 3,
  parameter logic [31:0] SsBase       = SS_BASE_DEFAULT
) (
  input  logic [31:0]     addr_i,
  input  logic [NUM_SS-1:0] ss_en_i,
  output logic            hit_o,
  output logic [IdxW-1:0] idx_o,
  output logic            allowed_o
);

  localparam logic [31:0] WinSpan = 32'(NUM_SS) << ApbAddrWidth;

  logic [31:0] offset;

  // Offset into the subsystem region; idx is only meaningful when hit_o is set.
  always_comb begin
    offset    = addr_i - SsBase;
    hit_o     = (addr_i >= SsBase) && (offset < WinSpan);
    idx_o     = IdxW'(offset >> ApbAddrWidth);
    allowed_o = hit_o && ss_en_i[idx_o];
  end

endmodule

// File: rtl/didactic_obi_apb_bridge.sv
// rtl/didactic_obi_apb_bridge.sv - single-outstanding OBI-to-APB bridge; DIDACTIC_APB_TIMEOUT_EN adds an ACCESS timeout
module didactic_obi_apb_bridge
  import didactic_obi_apb_pkg::*;
#(
  parameter int unsigned NUM_SS        = 5,
  parameter int unsigned ApbAddrWidth  = 12,
  parameter int unsigned ApbDataWidth  = 32,
  parameter int unsigned OBI_IDW       = ObiIdw,
  parameter logic [31:0] SsBase        = SS_BASE_DEFAULT,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         obi_req_i,
  output logic                         obi_gnt_o,
  input  logic [31:0]                  obi_addr_i,
  input  logic                         obi_we_i,
  input  logic [3:0]                   obi_be_i,
  input  logic [ApbDataWidth-1:0]      obi_wdata_i,
  input  logic [OBI_IDW-1:0]           obi_aid_i,
  output logic                         obi_rvalid_o,
  input  logic                         obi_rready_i,
  output logic [ApbDataWidth-1:0]      obi_rdata_o,
  output logic [OBI_IDW-1:0]           obi_rid_o,
  output logic                         obi_err_o,
  input  logic [NUM_SS-1:0]            ss_en_i,
  output logic [ApbAddrWidth-1:0]      paddr_o,
  output logic [ApbDataWidth-1:0]      pwdata_o,
  output logic                         pwrite_o,
  output logic [3:0]                   pstrb_o,
  output logic [NUM_SS-1:0]            psel_o,
  output logic                         penable_o,
  input  logic [NUM_SS*ApbDataWidth-1:0] prdata_i,
  input  logic [NUM_SS-1:0]            pready_i,
  input  logic [NUM_SS-1:0]            pslverr_i
);

  localparam int unsigned IdxW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  bridge_state_e             state_q, state_d;
  logic [ApbAddrWidth-1:0]   addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [ApbDataWidth-1:0]   wdata_q, wdata_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  obi_rsp_t                  rsp_q, rsp_d;

  logic                      dec_hit;
  logic [IdxW-1:0]           dec_idx;
  logic                      dec_allowed;
  logic                      sel_ready;
  logic                      sel_err;
  logic [ApbDataWidth-1:0]   sel_rdata;

`ifdef DIDACTIC_APB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  didactic_apb_addr_decode #(
    .NUM_SS       (NUM_SS),
    .ApbAddrWidth (ApbAddrWidth),
    .IdxW         (IdxW),
    .SsBase       (SsBase)
  ) u_decode (
    .addr_i    (obi_addr_i),
    .ss_en_i   (ss_en_i),
    .hit_o     (dec_hit),
    .idx_o     (dec_idx),
    .allowed_o (dec_allowed)
  );

  // Only the selected slave's handshake and data are looked at.
  assign sel_ready = pready_i[idx_q];
  assign sel_err   = pslverr_i[idx_q];
  assign sel_rdata = prdata_i[ApbDataWidth*idx_q +: ApbDataWidth];

  // Next-state logic, request capture and OBI handshake outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    rsp_d        = rsp_q;
    obi_gnt_o    = 1'b0;
    obi_rvalid_o = 1'b0;
`ifdef DIDACTIC_APB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) begin
          addr_d    = obi_addr_i[ApbAddrWidth-1:0];
          we_d      = obi_we_i;
          be_d      = obi_be_i;
          wdata_d   = obi_wdata_i;
          idx_d     = dec_idx;
          rsp_d.rid   = ObiIdw'(obi_aid_i);
          rsp_d.rdata = '0;
          rsp_d.err   = !(dec_hit && dec_allowed);
          state_d   = (dec_hit && dec_allowed) ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
`ifdef DIDACTIC_APB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          rsp_d.rdata = we_q ? '0 : sel_rdata;
          rsp_d.err   = sel_err;
          state_d     = ST_RESP;
        end
`ifdef DIDACTIC_APB_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end
      ST_RESP: begin
        obi_rvalid_o = 1'b1;
        if (obi_rready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef DIDACTIC_APB_TIMEOUT_EN
  // Counts ACCESS cycles spent waiting for pready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign psel_o    = (state_q == ST_SETUP || state_q == ST_ACCESS) ? (NUM_SS'(1) << idx_q) : '0;
  assign penable_o = (state_q == ST_ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = we_q;
  assign pstrb_o   = we_q ? be_q : 4'b0000;
  assign pwdata_o  = wdata_q;

  assign obi_rdata_o = rsp_q.rdata;
  assign obi_err_o   = rsp_q.err;
  assign obi_rid_o   = OBI_IDW'(rsp_q.rid);

endmodule

// File: tb/tb_didactic_obi_apb_bridge.sv
// tb/tb_didactic_obi_apb_bridge.sv - directed self-checking bench for the OBI-to-APB bridge
module tb_didactic_obi_apb_bridge;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         obi_req_i;
  logic         obi_gnt_o;
  logic [31:0]  obi_addr_i;
  logic         obi_we_i;
  logic [3:0]   obi_be_i;
  logic [31:0]  obi_wdata_i;
  logic [0:0]   obi_aid_i;
  logic         obi_rvalid_o;
  logic         obi_rready_i;
  logic [31:0]  obi_rdata_o;
  logic [0:0]   obi_rid_o;
  logic         obi_err_o;
  logic [4:0]   ss_en_i;
  logic [11:0]  paddr_o;
  logic [31:0]  pwdata_o;
  logic         pwrite_o;
  logic [3:0]   pstrb_o;
  logic [4:0]   psel_o;
  logic         penable_o;
  logic [159:0] prdata_i;
  logic [4:0]   pready_i;
  logic [4:0]   pslverr_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_gnt    = 0;
  int lat;
  int wait_cfg = 0;
  int acc_cnt;
  int psel_cnt = 0;
  int p0;

  didactic_obi_apb_bridge #(
    .NUM_SS        (5),
    .ApbAddrWidth  (12),
    .ApbDataWidth  (32),
    .OBI_IDW       (1),
    .SsBase        (32'h0100_0000),
    .TimeoutCycles (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_aid_i    (obi_aid_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_rid_o    (obi_rid_o),
    .obi_err_o    (obi_err_o),
    .ss_en_i      (ss_en_i),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pwrite_o     (pwrite_o),
    .pstrb_o      (pstrb_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Slave model: pready rises after wait_cfg ACCESS cycles.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_cnt <= 0;
    else if (penable_o) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready_i = (penable_o && acc_cnt >= wait_cfg) ? 5'b11111 : 5'b00000;

  always @(negedge clk_i) if (psel_o != 5'b00000) psel_cnt <= psel_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic [0:0] id);
    @(posedge clk_i); #1;
    obi_req_i   = 1'b1;
    obi_addr_i  = a;
    obi_we_i    = w;
    obi_be_i    = b;
    obi_wdata_i = d;
    obi_aid_i   = id;
    @(negedge clk_i);
    chk("gnt", 64'(obi_gnt_o), 64'd1);
    t_gnt = cyc;
    @(posedge clk_i); #1;
    obi_req_i = 1'b0;
  endtask

  task automatic wait_rvalid(output int l);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!obi_rvalid_o && n < 2000);
    l = cyc - t_gnt;
  endtask

  task automatic respond();
    obi_rready_i = 1'b1;
    @(posedge clk_i); #1;
    obi_rready_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    obi_req_i    = 1'b0;
    obi_addr_i   = '0;
    obi_we_i     = 1'b0;
    obi_be_i     = '0;
    obi_wdata_i  = '0;
    obi_aid_i    = '0;
    obi_rready_i = 1'b0;
    ss_en_i      = 5'b11111;
    pslverr_i    = 5'b00000;
    prdata_i     = {32'h4444_0004, 32'h3333_0003, 32'hCAFE_0123, 32'hB0B1_0001, 32'h0000_0A00};
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_obi", 64'({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o}), 64'd0);
    chk("reset_apb", 64'({paddr_o, pwrite_o, pstrb_o, psel_o, penable_o}), 64'd0);
    chk("reset_pwdata", 64'(pwdata_o), 64'd0);
    rst_ni = 1'b1;

    // Zero-wait read of subsystem 2
    issue(32'h0100_2004, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk_i);
    chk("rd_setup_psel", 64'(psel_o), 64'b00100);
    chk("rd_setup_pen", 64'(penable_o), 64'd0);
    chk("rd_paddr", 64'(paddr_o), 64'h004);
    chk("rd_pwrite_pstrb", 64'({pwrite_o, pstrb_o}), 64'd0);
    wait_rvalid(lat);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_rdata", 64'(obi_rdata_o), 64'hCAFE_0123);
    chk("rd_err", 64'(obi_err_o), 64'd0);
    chk("rd_rid", 64'(obi_rid_o), 64'd1);
    respond();

    // Write with two wait states
    wait_cfg = 2;
    issue(32'h0100_0010, 1'b1, 4'b0011, 32'h1234_5678, 1'b0);
    @(negedge clk_i);
    chk("wr_setup", 64'({psel_o, penable_o, paddr_o, pwrite_o, pstrb_o}),
        64'({5'b00001, 1'b0, 12'h010, 1'b1, 4'b0011}));
    chk("wr_pwdata", 64'(pwdata_o), 64'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("wr_access", 64'({psel_o, penable_o, paddr_o, pwrite_o, pstrb_o}),
          64'({5'b00001, 1'b1, 12'h010, 1'b1, 4'b0011}));
      chk("wr_access_pwdata", 64'(pwdata_o), 64'h1234_5678);
    end
    wait_rvalid(lat);
    chk("wr_lat", 64'(lat), 64'd5);
    chk("wr_resp", 64'({obi_err_o, obi_rdata_o, obi_rid_o}), 64'd0);
    respond();
    wait_cfg = 0;

    // Disabled subsystem and out-of-range window: no APB activity
    p0 = psel_cnt;
    ss_en_i = 5'b10111;
    issue(32'h0100_3000, 1'b0, 4'hF, 32'h0, 1'b1);
    wait_rvalid(lat);
    chk("dis_lat", 64'(lat), 64'd1);
    chk("dis_resp", 64'({obi_err_o, obi_rdata_o, obi_rid_o}), 64'({1'b1, 32'h0, 1'b1}));
    respond();
    ss_en_i = 5'b11111;
    issue(32'h0100_5000, 1'b1, 4'hF, 32'h5555_AAAA, 1'b0);
    wait_rvalid(lat);
    chk("miss_hi_lat", 64'(lat), 64'd1);
    chk("miss_hi_resp", 64'({obi_err_o, obi_rdata_o}), 64'({1'b1, 32'h0}));
    respond();
    issue(32'h00FF_FFFC, 1'b0, 4'hF, 32'h0, 1'b0);
    wait_rvalid(lat);
    chk("miss_lo_lat", 64'(lat), 64'd1);
    chk("miss_lo_err", 64'(obi_err_o), 64'd1);
    respond();
    @(negedge clk_i);
    chk("no_psel_on_err", 64'(psel_cnt - p0), 64'd0);

    // Last word of the top window
    issue(32'h0100_4FFC, 1'b0, 4'hF, 32'h0, 1'b1);
    @(negedge clk_i);
    chk("top_psel_paddr", 64'({psel_o, paddr_o}), 64'({5'b10000, 12'hFFC}));
    wait_rvalid(lat);
    chk("top_lat", 64'(lat), 64'd3);
    chk("top_resp", 64'({obi_err_o, obi_rdata_o}), 64'({1'b0, 32'h4444_0004}));
    respond();

    // Slave error with stalled rready, then back-to-back grant
    pslverr_i = 5'b00010;
    issue(32'h0100_1008, 1'b0, 4'hF, 32'h0, 1'b1);
    wait_rvalid(lat);
    chk("slverr_lat", 64'(lat), 64'd3);
    obi_req_i  = 1'b1;
    obi_addr_i = 32'h0100_1000;
    obi_we_i   = 1'b0;
    obi_aid_i  = 1'b0;
    pslverr_i  = 5'b11101;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_i);
      chk("slverr_hold", 64'({obi_rvalid_o, obi_err_o, obi_rid_o, obi_gnt_o}), 64'b1110);
    end
    @(negedge clk_i);
    obi_rready_i = 1'b1;
    @(posedge clk_i); #1;
    obi_rready_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_gnt", 64'(obi_gnt_o), 64'd1);
    t_gnt = cyc;
    @(posedge clk_i); #1;
    obi_req_i = 1'b0;
    wait_rvalid(lat);
    chk("b2b_lat", 64'(lat), 64'd3);
    chk("b2b_resp", 64'({obi_err_o, obi_rdata_o, obi_rid_o}), 64'({1'b0, 32'hB0B1_0001, 1'b0}));
    respond();
    pslverr_i = 5'b00000;

    // pready stuck low
    wait_cfg = 1000000;
    issue(32'h0100_0000, 1'b0, 4'hF, 32'h0, 1'b1);
`ifdef DIDACTIC_APB_TIMEOUT_EN
    wait_rvalid(lat);
    chk("tmo_lat", 64'(lat), 64'd10);
    chk("tmo_resp", 64'({obi_err_o, obi_rdata_o}), 64'({1'b1, 32'h0}));
    chk("tmo_apb_idle", 64'({psel_o, penable_o}), 64'd0);
    respond();
    issue(32'h0100_0000, 1'b0, 4'hF, 32'h0, 1'b1);
    repeat (3) @(negedge clk_i);
`else
    repeat (1000) @(negedge clk_i);
    chk("stuck_rvalid", 64'(obi_rvalid_o), 64'd0);
`endif
    chk("stuck_access", 64'({psel_o, penable_o}), 64'({5'b00001, 1'b1}));

    // Asynchronous reset mid-ACCESS
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_obi", 64'({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o}), 64'd0);
    chk("arst_apb", 64'({paddr_o, pwrite_o, pstrb_o, psel_o, penable_o}), 64'd0);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    wait_cfg = 0;
    issue(32'h0100_2000, 1'b0, 4'hF, 32'h0, 1'b0);
    wait_rvalid(lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_resp", 64'({obi_err_o, obi_rdata_o}), 64'({1'b0, 32'hCAFE_0123}));
    respond();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
